// File: rtl/pattern_producer.sv
// pattern_producer: framed test-packet source (header, payload, XOR trailer, gap) feeding a downstream FIFO.
module pattern_producer #(
    parameter int          DW    = 32,
    parameter int          LEN_W = 16,
    parameter logic [31:0] SEED  = 32'h1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [LEN_W-1:0] gap_i,
    input  logic [DW-1:0]    const_i,
    input  logic             fifo_full_i,
    input  logic             fifo_almst_full_i,
    output logic             fifo_wr_o,
    output logic [DW-1:0]    data_o,
    output logic             sop_o,
    output logic             eop_o,
    output logic             busy_o,
    output logic [31:0]      pkt_cnt_o,
    output logic             ovf_o
);
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, TRAILER, GAP} state_t;

    state_t             state_q, state_d;
    logic               wr_q, wr_d, sop_q, sop_d, eop_q, eop_d, ovf_q, ovf_d;
    logic [DW-1:0]      data_q, data_d, acc_q, acc_d, walk_q, walk_d, const_q, const_d, pay;
    logic [31:0]        pkt_q, pkt_d, lfsr_q, lfsr_d;
    logic [LEN_W-1:0]   idx_q, idx_d, gcnt_q, gcnt_d, len_q, len_d, gap_q, gap_d;
    logic [1:0]         mode_q, mode_d;
    logic               go;
    state_t             nxt;

    assign go = !fifo_almst_full_i && !fifo_full_i;
    assign nxt = en_i ? HEADER : IDLE;

    always_comb begin
        state_d = state_q;
        wr_d    = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        data_d  = data_q;
        acc_d   = acc_q;
        walk_d  = walk_q;
        lfsr_d  = lfsr_q;
        pkt_d   = pkt_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        len_d   = len_q;
        gap_d   = gap_q;
        mode_d  = mode_q;
        const_d = const_q;
        ovf_d   = ovf_q | (wr_q & fifo_full_i);
        pay     = mode_q == 2'b00 ? DW'(idx_q) :
                  mode_q == 2'b01 ? walk_q :
                  mode_q == 2'b10 ? lfsr_q[DW-1:0] : const_q;
        case (state_q)
            IDLE: state_d = nxt;
            HEADER: if (go) begin
                wr_d    = 1'b1;
                sop_d   = 1'b1;
                data_d  = {8'hA5, pkt_q[DW-9:0]};
                acc_d   = '0;
                idx_d   = '0;
                walk_d  = DW'(1);
                state_d = len_q == '0 ? TRAILER : PAYLOAD;
            end
            PAYLOAD: if (go) begin
                wr_d    = 1'b1;
                data_d  = pay;
                acc_d   = acc_q ^ pay;
                idx_d   = idx_q + LEN_W'(1);
                walk_d  = {walk_q[DW-2:0], walk_q[DW-1]};
                lfsr_d  = mode_q == 2'b10 ? {lfsr_q[30:0], lfsr_q[30] ^ lfsr_q[27]} : lfsr_q;
                state_d = idx_q == len_q - LEN_W'(1) ? TRAILER : PAYLOAD;
            end
            TRAILER: if (go) begin
                wr_d    = 1'b1;
                eop_d   = 1'b1;
                data_d  = acc_q;
                pkt_d   = pkt_q + 32'd1;
                gcnt_d  = '0;
                state_d = gap_q == '0 ? nxt : GAP;
            end
            GAP: begin
                gcnt_d  = gcnt_q + LEN_W'(1);
                state_d = gcnt_q == gap_q - LEN_W'(1) ? nxt : GAP;
            end
            default: state_d = IDLE;
        endcase
        // configuration is captured at every packet start, so it is frozen for the packet's lifetime
        if (state_d == HEADER && state_q != HEADER) begin
            len_d   = len_i;
            gap_d   = gap_i;
            mode_d  = mode_i;
            const_d = const_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            acc_q   <= '0;
            walk_q  <= '0;
            const_q <= '0;
            pkt_q   <= '0;
            lfsr_q  <= SEED;
            idx_q   <= '0;
            gcnt_q  <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            walk_q  <= walk_d;
            const_q <= const_d;
            pkt_q   <= pkt_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            mode_q  <= mode_d;
        end
    end

    assign fifo_wr_o = wr_q;
    assign data_o    = data_q;
    assign sop_o     = sop_q;
    assign eop_o     = eop_q;
    assign busy_o    = state_q != IDLE;
    assign pkt_cnt_o = pkt_q;
    assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_pattern_producer.sv
// tb_pattern_producer: scoreboard bench for pattern_producer with a packet-level reference model.
module tb_pattern_producer;
    localparam int          DW    = 32;
    localparam int          LEN_W = 16;
    localparam logic [31:0] SEED  = 32'h1;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             en_i = 1'b0;
    logic [1:0]       mode_i = '0;
    logic [LEN_W-1:0] len_i = '0;
    logic [LEN_W-1:0] gap_i = '0;
    logic [DW-1:0]    const_i = '0;
    logic             fifo_full_i = 1'b0;
    logic             fifo_almst_full_i = 1'b0;
    logic             fifo_wr_o, sop_o, eop_o, busy_o, ovf_o;
    logic [DW-1:0]    data_o;
    logic [31:0]      pkt_cnt_o;

    pattern_producer #(.DW(DW), .LEN_W(LEN_W), .SEED(SEED)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i), .len_i(len_i),
        .gap_i(gap_i), .const_i(const_i), .fifo_full_i(fifo_full_i),
        .fifo_almst_full_i(fifo_almst_full_i), .fifo_wr_o(fifo_wr_o), .data_o(data_o),
        .sop_o(sop_o), .eop_o(eop_o), .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int            checks = 0, errors = 0, sop_seen = 0;
    logic [DW+1:0] sb[$];
    logic [31:0]   m_lfsr = SEED, m_seq = 0;
    logic          thr_en = 1'b0;

    task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // expected words of one packet: {sop, eop, data}
    task automatic push_pkt(input int mode, input int len, input logic [DW-1:0] cv);
        logic [DW-1:0] acc, w;
        acc = '0;
        sb.push_back({2'b10, 8'hA5, m_seq[DW-9:0]});
        for (int i = 0; i < len; i++) begin
            case (mode)
                0: w = DW'(i);
                1: w = DW'(1) << (i % DW);
                2: begin
                    w = m_lfsr[DW-1:0];
                    m_lfsr = {m_lfsr[30:0], m_lfsr[30] ^ m_lfsr[27]};
                end
                default: w = cv;
            endcase
            acc ^= w;
            sb.push_back({2'b00, w});
        end
        sb.push_back({2'b01, acc});
        m_seq++;
    endtask

    task automatic wait_sops(input int tgt);
        int n = 0;
        while (sop_seen < tgt && n < 3000) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("sop_timeout", sop_seen >= tgt, 64'(sop_seen), 64'(tgt));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 3000) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("idle_timeout", !busy_o, 64'(busy_o), 64'(0));
    endtask

    task automatic run_pkts(input int mode, input int len, input int gap, input logic [DW-1:0] cv,
                            input int n, input logic thr);
        @(negedge clk_i);
        mode_i  = 2'(mode);
        len_i   = LEN_W'(len);
        gap_i   = LEN_W'(gap);
        const_i = cv;
        thr_en  = thr;
        for (int k = 0; k < n; k++) push_pkt(mode, len, cv);
        en_i = 1'b1;
        wait_sops(sop_seen + n);
        en_i = 1'b0;
        wait_idle();
        thr_en = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("sb_drained", sb.size() == 0, 64'(sb.size()), 64'(0));
        chk("pkt_cnt", pkt_cnt_o == m_seq, 64'(pkt_cnt_o), 64'(m_seq));
    endtask

    task automatic chk_reset_state();
        chk("rst_wr", fifo_wr_o == 1'b0, 64'(fifo_wr_o), 64'(0));
        chk("rst_data", data_o == '0, 64'(data_o), 64'(0));
        chk("rst_sop_eop", {sop_o, eop_o} == 2'b00, 64'({sop_o, eop_o}), 64'(0));
        chk("rst_busy", busy_o == 1'b0, 64'(busy_o), 64'(0));
        chk("rst_pkt_cnt", pkt_cnt_o == 32'd0, 64'(pkt_cnt_o), 64'(0));
        chk("rst_ovf", ovf_o == 1'b0, 64'(ovf_o), 64'(0));
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk_i);
                if (!rst_i && fifo_wr_o) begin
                    if (sop_o) sop_seen++;
                    if (sb.size() == 0) chk("unexpected_word", 1'b0, 64'({sop_o, eop_o, data_o}), 64'(0));
                    else begin
                        logic [DW+1:0] e;
                        e = sb.pop_front();
                        chk("word", {sop_o, eop_o, data_o} === e, 64'({sop_o, eop_o, data_o}), 64'(e));
                    end
                end
            end
            forever begin
                @(negedge clk_i);
                fifo_almst_full_i = thr_en && ($urandom_range(0, 3) == 0);
            end
            begin
                #2000000;
                $display("FAIL watchdog: got timeout, required completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (3) @(negedge clk_i);
        chk_reset_state();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk_reset_state();

        run_pkts(0, 4, 2, '0, 1, 1'b0);
        run_pkts(1, 34, 1, '0, 1, 1'b0);
        run_pkts(2, 8, 0, '0, 2, 1'b0);
        run_pkts(0, 10, 3, '0, 1, 1'b1);
        run_pkts(3, 0, 0, 32'hDEADBEEF, 2, 1'b1);
        for (int r = 0; r < 12; r++)
            run_pkts($urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 3),
                     DW'($urandom), $urandom_range(1, 3), 1'b1);
        chk("ovf_clear", ovf_o == 1'b0, 64'(ovf_o), 64'(0));

        // overflow: assert full while a write is being presented
        @(negedge clk_i);
        mode_i = 2'b11;
        len_i = LEN_W'(6);
        gap_i = '0;
        const_i = 32'h12345678;
        push_pkt(3, 6, 32'h12345678);
        en_i = 1'b1;
        wait_sops(sop_seen + 1);
        en_i = 1'b0;
        chk("ovf_wr_present", fifo_wr_o == 1'b1, 64'(fifo_wr_o), 64'(1));
        fifo_full_i = 1'b1;
        @(negedge clk_i);
        fifo_full_i = 1'b0;
        chk("ovf_set", ovf_o == 1'b1, 64'(ovf_o), 64'(1));
        wait_idle();
        repeat (3) @(negedge clk_i);
        chk("ovf_sticky", ovf_o == 1'b1, 64'(ovf_o), 64'(1));
        chk("ovf_sb_drained", sb.size() == 0, 64'(sb.size()), 64'(0));

        // en dropped during payload, then reset in the middle of the next packet
        run_pkts(0, 3, 2, '0, 1, 1'b0);
        @(negedge clk_i);
        len_i = LEN_W'(20);
        push_pkt(0, 20, '0);
        en_i = 1'b1;
        wait_sops(sop_seen + 1);
        en_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_reset_state();
        rst_i = 1'b0;
        sb.delete();
        m_seq = 0;
        m_lfsr = SEED;
        run_pkts(2, 5, 1, '0, 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
